tx_fill_tracker: RTL and testbench

- Per-buffer fill-level tracker for the TX DMA path in the s_ul_clk domain, generalised to 2^IDX_BITS buffers of WIDTH-bit byte counts.
- The producer arms a buffer with its expected size. Completed write parts then subtract from that buffer's count.
- When the buffer at `cur_buf_num` is armed and its count is zero, the block issues a registered `inc_buf` pulse. The consumer uses that pulse to advance its buffer pointer.
- Adds three things:
  - per-buffer armed bits, so unused slots never complete;
  - back-to-back completion of several finished buffers;
  - sticky error reporting for underflow and stray decrements.

---
 rtl/tx_fill_pkg.sv | 11 +
 rtl/ram_dist_sp.sv | 25 ++
 rtl/tx_fill_tracker.sv | 167 ++++++++++++++++
 tb/tb_tx_fill_tracker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_fill_pkg.sv
// Shared definitions for the TX DMA per-buffer fill tracker.
// The state encoding is also visible on the tracker's debug port.
package tx_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HOLD  = 2'd2
  } fill_state_e;

endpackage

// File: rtl/ram_dist_sp.sv
// Single-port distributed RAM: asynchronous read, synchronous write, shared address.
module ram_dist_sp #(
  parameter int ADDR_BITS = 5,
  parameter int WIDTH     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [WIDTH-1:0]     i_wdata,
  output logic [WIDTH-1:0]     o_rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/tx_fill_tracker.sv
// Per-buffer fill-level tracker for the TX DMA path: arms buffers with an expected
// size, subtracts completed parts, and pulses inc_buf when the consumer's buffer drains.
module tx_fill_tracker
  import tx_fill_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int IDX_BITS = 5
) (
  input  logic                s_ul_clk,
  input  logic                reset,
  input  logic                incb_valid,
  output logic                incb_ready,
  input  logic [WIDTH-1:0]    incb_size,
  input  logic [IDX_BITS-1:0] incb_idx,
  input  logic                decb_valid,
  input  logic [WIDTH-1:0]    decb_size,
  input  logic [IDX_BITS-1:0] decb_idx,
  input  logic [IDX_BITS-1:0] cur_buf_num,
  output logic                inc_buf,
  output logic [IDX_BITS-1:0] done_idx,
  output logic                err_underflow,
  output logic                err_stray,
  input  logic                err_clr,
  output logic [1:0]          dbg_state
);

  localparam int DEPTH = 1 << IDX_BITS;

  fill_state_e         r_state;
  fill_state_e         w_state_nxt;
  logic [DEPTH-1:0]    r_armed;
  logic                r_inc_buf;
  logic [IDX_BITS-1:0] r_done_idx;
  logic                r_err_underflow;
  logic                r_err_stray;

  logic                w_inc_acc;
  logic                w_we;
  logic [IDX_BITS-1:0] w_addr;
  logic [WIDTH-1:0]    w_rdata;
  logic [WIDTH-1:0]    w_wdata;
  logic                w_complete;
  logic                w_uflow;
  logic                w_stray;

  // Handshake: an arm transfers on a cycle where incb_valid && incb_ready; incb_ready
  // depends only on decb_valid and state (never on incb_valid). decb has no ready:
  // every cycle with decb_valid high is a transfer and it wins the single RAM port.
  assign incb_ready = !decb_valid && (r_state == ST_IDLE);
  assign w_inc_acc  = incb_valid && incb_ready;

  always_comb begin
    w_addr = cur_buf_num;
    if (decb_valid) begin
      w_addr = decb_idx;
    end else if (w_inc_acc) begin
      w_addr = incb_idx;
    end
  end

  // Subtraction saturates at zero; an oversized part is reported, not wrapped.
  assign w_uflow = decb_valid && (decb_size > w_rdata);
  assign w_stray = decb_valid && !r_armed[decb_idx];

  always_comb begin
    w_wdata = incb_size;
    if (decb_valid) begin
      w_wdata = w_uflow ? '0 : (w_rdata - decb_size);
    end
  end

  assign w_we = !reset && (decb_valid || w_inc_acc);

  ram_dist_sp #(
    .ADDR_BITS(IDX_BITS),
    .WIDTH    (WIDTH)
  ) u_count_ram (
    .i_clk  (s_ul_clk),
    .i_we   (w_we),
    .i_addr (w_addr),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge s_ul_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A decrement always forces a fresh CHECK, whatever the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    if (decb_valid) begin
      w_state_nxt = ST_CHECK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_inc_acc) begin
            w_state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_armed[cur_buf_num] && (w_rdata == '0)) begin
            w_complete  = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HOLD: begin
          w_state_nxt = ST_CHECK;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Arming and completion never coincide: arms land in IDLE, completions in CHECK.
  always_ff @(posedge s_ul_clk) begin
    if (reset) begin
      r_armed <= '0;
    end else begin
      if (w_inc_acc) begin
        r_armed[incb_idx] <= 1'b1;
      end
      if (w_complete) begin
        r_armed[cur_buf_num] <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_ul_clk) begin
    if (reset) begin
      r_inc_buf  <= 1'b0;
      r_done_idx <= '0;
    end else begin
      r_inc_buf <= w_complete;
      if (w_complete) begin
        r_done_idx <= cur_buf_num;
      end
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge s_ul_clk) begin
    if (reset) begin
      r_err_underflow <= 1'b0;
      r_err_stray     <= 1'b0;
    end else begin
      r_err_underflow <= w_uflow || (r_err_underflow && !err_clr);
      r_err_stray     <= w_stray || (r_err_stray && !err_clr);
    end
  end

  assign inc_buf       = r_inc_buf;
  assign done_idx      = r_done_idx;
  assign err_underflow = r_err_underflow;
  assign err_stray     = r_err_stray;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_tx_fill_tracker.sv
// Directed bench for tx_fill_tracker: arms, drains and error cases with hand-computed
// pulse indices and pulse cycles.
module tb_tx_fill_tracker;
  import tx_fill_pkg::*;

  localparam int WIDTH    = 16;
  localparam int IDX_BITS = 5;

  logic                s_ul_clk = 1'b0;
  logic                reset = 1'b1;
  logic                incb_valid = 1'b0;
  logic                incb_ready;
  logic [WIDTH-1:0]    incb_size = '0;
  logic [IDX_BITS-1:0] incb_idx = '0;
  logic                decb_valid = 1'b0;
  logic [WIDTH-1:0]    decb_size = '0;
  logic [IDX_BITS-1:0] decb_idx = '0;
  logic [IDX_BITS-1:0] cur_buf_num = '0;
  logic                inc_buf;
  logic [IDX_BITS-1:0] done_idx;
  logic                err_underflow;
  logic                err_stray;
  logic                err_clr = 1'b0;
  logic [1:0]          dbg_state;

  tx_fill_tracker #(.WIDTH(WIDTH), .IDX_BITS(IDX_BITS)) dut (
    .s_ul_clk     (s_ul_clk),
    .reset        (reset),
    .incb_valid   (incb_valid),
    .incb_ready   (incb_ready),
    .incb_size    (incb_size),
    .incb_idx     (incb_idx),
    .decb_valid   (decb_valid),
    .decb_size    (decb_size),
    .decb_idx     (decb_idx),
    .cur_buf_num  (cur_buf_num),
    .inc_buf      (inc_buf),
    .done_idx     (done_idx),
    .err_underflow(err_underflow),
    .err_stray    (err_stray),
    .err_clr      (err_clr),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 s_ul_clk = ~s_ul_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int                  n_checks = 0;
  int                  n_fail = 0;
  int                  cyc = 0;
  logic                auto_adv = 1'b0;
  logic [IDX_BITS-1:0] exp_q[$];
  int                  pcyc_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge s_ul_clk);
    #1;
    cyc++;
    if (inc_buf === 1'b1) begin
      pcyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(inc_buf), 32'd0);
      end else begin
        check("done_idx", 32'(done_idx), 32'(exp_q.pop_front()));
      end
      if (auto_adv) begin
        cur_buf_num = cur_buf_num + 1'b1;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // driver tasks
  task automatic arm(input int idx, input int size, output int acc_cyc);
    incb_valid = 1'b1;
    incb_idx   = IDX_BITS'(idx);
    incb_size  = WIDTH'(size);
    #1;
    for (int i = 0; i < 20 && incb_ready !== 1'b1; i++) begin
      tick();
    end
    check("arm_ready", 32'(incb_ready), 32'd1);
    acc_cyc = cyc;
    tick();
    incb_valid = 1'b0;
  endtask

  task automatic dec(input int idx, input int size, output int dcyc);
    decb_valid = 1'b1;
    decb_idx   = IDX_BITS'(idx);
    decb_size  = WIDTH'(size);
    dcyc       = cyc;
    tick();
    decb_valid = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  int a, d, d0, t;

  initial begin
    run(2);
    reset = 1'b0;
    #1;
    check("rst_inc_buf", 32'(inc_buf), 32'd0);
    check("rst_done_idx", 32'(done_idx), 32'd0);
    check("rst_err_uf", 32'(err_underflow), 32'd0);
    check("rst_err_stray", 32'(err_stray), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_ready", 32'(incb_ready), 32'd1);

    // Single buffer drained by two parts.
    pcyc_q.delete();
    arm(0, 256, a);
    dec(0, 128, d);
    exp_q.push_back(0);
    dec(0, 128, d);
    run(6);
    check("t1_pulse_cnt", 32'(pcyc_q.size()), 32'd1);
    check("t1_latency", 32'(pcyc_q[0]), 32'(d + 2));
    check("t1_err_uf", 32'(err_underflow), 32'd0);
    check("t1_err_stray", 32'(err_stray), 32'd0);

    // Three finished buffers complete back to back.
    pcyc_q.delete();
    cur_buf_num = '0;
    auto_adv = 1'b1;
    arm(0, 64, a);
    arm(1, 64, a);
    arm(2, 64, a);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    dec(0, 64, d0);
    dec(1, 64, d);
    dec(2, 64, d);
    run(10);
    check("t2_pulse_cnt", 32'(pcyc_q.size()), 32'd3);
    check("t2_pulse0", 32'(pcyc_q[0]), 32'(d0 + 4));
    check("t2_pulse1", 32'(pcyc_q[1]), 32'(d0 + 6));
    check("t2_pulse2", 32'(pcyc_q[2]), 32'(d0 + 8));
    check("t2_left", 32'(exp_q.size()), 32'd0);

    // Inc/dec collision: dec wins, inc waits for IDLE.
    arm(4, 50, a);
    incb_valid = 1'b1;
    incb_idx   = 5'd5;
    incb_size  = 16'd10;
    decb_valid = 1'b1;
    decb_idx   = 5'd4;
    decb_size  = 16'd20;
    #1;
    check("t3_ready_collide", 32'(incb_ready), 32'd0);
    tick();
    decb_valid = 1'b0;
    #1;
    check("t3_ready_in_check", 32'(incb_ready), 32'd0);
    check("t3_state_check", 32'(dbg_state), 32'(ST_CHECK));
    tick();
    check("t3_ready_idle", 32'(incb_ready), 32'd1);
    tick();
    incb_valid = 1'b0;
    cur_buf_num = 5'd4;
    run(2);
    exp_q.push_back(4);
    dec(4, 30, d);
    run(4);
    exp_q.push_back(5);
    dec(5, 10, d);
    run(4);
    check("t3_left", 32'(exp_q.size()), 32'd0);
    check("t3_err_uf", 32'(err_underflow), 32'd0);
    check("t3_err_stray", 32'(err_stray), 32'd0);

    // Underflow clamps to zero and is sticky until err_clr.
    arm(3, 40, a);
    dec(3, 100, d);
    check("t4_uf_set", 32'(err_underflow), 32'd1);
    run(3);
    check("t4_uf_held", 32'(err_underflow), 32'd1);
    check("t4_stray_clean", 32'(err_stray), 32'd0);
    cur_buf_num = 5'd3;
    exp_q.push_back(3);
    dec(3, 0, d);
    run(4);
    check("t4_clamped_done", 32'(exp_q.size()), 32'd0);
    check("t4_uf_still", 32'(err_underflow), 32'd1);
    clear_errors();
    check("t4_uf_cleared", 32'(err_underflow), 32'd0);
    err_clr = 1'b1;
    dec(3, 5, d);
    err_clr = 1'b0;
    check("t4_clr_vs_uf", 32'(err_underflow), 32'd1);
    check("t4_clr_vs_stray", 32'(err_stray), 32'd1);
    run(2);
    clear_errors();
    check("t4_uf_clr2", 32'(err_underflow), 32'd0);
    check("t4_stray_clr2", 32'(err_stray), 32'd0);

    // Stray decrement; zero-size arm of the last index.
    pcyc_q.delete();
    dec(7, 1, d);
    run(3);
    check("t5_stray", 32'(err_stray), 32'd1);
    check("t5_no_pulse", 32'(pcyc_q.size()), 32'd0);
    clear_errors();
    cur_buf_num = 5'd31;
    exp_q.push_back(31);
    arm(31, 0, a);
    run(4);
    check("t5_zero_cnt", 32'(pcyc_q.size()), 32'd1);
    check("t5_zero_lat", 32'(pcyc_q[0]), 32'(a + 2));
    check("t5_err_stray", 32'(err_stray), 32'd0);

    // Reset during HOLD aborts the pending completion and disarms everything.
    cur_buf_num = 5'd10;
    arm(10, 20, a);
    arm(11, 20, a);
    dec(11, 20, d);
    run(2);
    pcyc_q.delete();
    exp_q.push_back(10);
    dec(10, 20, d);
    t = 0;
    while (pcyc_q.size() == 0 && t < 10) begin
      tick();
      t++;
    end
    check("t6_pulse_seen", 32'(pcyc_q.size()), 32'd1);
    check("t6_state_hold", 32'(dbg_state), 32'(ST_HOLD));
    reset = 1'b1;
    tick();
    check("t6_rst_inc_buf", 32'(inc_buf), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t6_rst_done_idx", 32'(done_idx), 32'd0);
    reset = 1'b0;
    run(4);
    check("t6_no_late_pulse", 32'(pcyc_q.size()), 32'd1);
    dec(11, 0, d);
    run(3);
    check("t6_stray_after_rst", 32'(err_stray), 32'd1);
    check("t6_no_pulse_11", 32'(pcyc_q.size()), 32'd1);
    check("t6_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
